// File: rtl/id_ex_register.sv
// ID/EX pipeline register for a 32-bit MIPS 5-stage pipeline.
// Registers the decoded control bits, operand data, immediate, register
// numbers and PC+4 for the EX stage. It also supports stall (hold), flush
// (bubble insertion) and a saturating count of bubbles entering EX.
module id_ex_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Stall_In,
    input  logic                      Flush_In,
    input  logic                      Clear_Count_In,
    input  logic                      Valid_In,
    input  logic                      Reg_Write_In,
    input  logic                      Mem_To_Reg_In,
    input  logic                      Mem_Read_In,
    input  logic                      Mem_Write_In,
    input  logic                      Reg_Dst_In,
    input  logic                      Alu_Src_In,
    input  logic [1:0]                Alu_OP_In,
    input  logic [DATA_WIDTH-1:0]     Read_Data_1_In,
    input  logic [DATA_WIDTH-1:0]     Read_Data_2_In,
    input  logic [DATA_WIDTH-1:0]     Sign_Ext_Imm_In,
    input  logic [DATA_WIDTH-1:0]     PC_Plus4_In,
    input  logic [REG_ADDR_WIDTH-1:0] Rs_In,
    input  logic [REG_ADDR_WIDTH-1:0] Rt_In,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_In,
    output logic                      Reg_Write_Out,
    output logic                      Mem_To_Reg_Out,
    output logic                      Mem_Read_Out,
    output logic                      Mem_Write_Out,
    output logic                      Reg_Dst_Out,
    output logic                      Alu_Src_Out,
    output logic [1:0]                Alu_OP_Out,
    output logic [DATA_WIDTH-1:0]     Read_Data_1_Out,
    output logic [DATA_WIDTH-1:0]     Read_Data_2_Out,
    output logic [DATA_WIDTH-1:0]     Sign_Ext_Imm_Out,
    output logic [DATA_WIDTH-1:0]     PC_Plus4_Out,
    output logic [REG_ADDR_WIDTH-1:0] Rs_Out,
    output logic [REG_ADDR_WIDTH-1:0] Rt_Out,
    output logic [REG_ADDR_WIDTH-1:0] Rd_Out,
    output logic                      Valid_Out,
    output logic [COUNT_WIDTH-1:0]    Bubble_Count_Out
);

    // A bubble enters EX when this stage is flushed, or when it loads an
    // instruction that IF/ID has already marked as not real. A stalled
    // stage holds its contents, so nothing new enters EX.
    logic bubble;
    logic load;
    logic count_full;

    assign load       = !Flush_In && !Stall_In;
    assign bubble     = Flush_In || (load && !Valid_In);
    assign count_full = (Bubble_Count_Out == {COUNT_WIDTH{1'b1}});

    // Control bits and valid flag: cleared by reset or flush, held on stall.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments keep every flop sampling its
        // pre-edge inputs, so the stage updates as one atomic register.
        if (Rst) begin
            Reg_Write_Out  <= 1'b0;
            Mem_To_Reg_Out <= 1'b0;
            Mem_Read_Out   <= 1'b0;
            Mem_Write_Out  <= 1'b0;
            Reg_Dst_Out    <= 1'b0;
            Alu_Src_Out    <= 1'b0;
            Alu_OP_Out     <= 2'b00;
            Valid_Out      <= 1'b0;
        end else if (Flush_In) begin
            Reg_Write_Out  <= 1'b0;
            Mem_To_Reg_Out <= 1'b0;
            Mem_Read_Out   <= 1'b0;
            Mem_Write_Out  <= 1'b0;
            Reg_Dst_Out    <= 1'b0;
            Alu_Src_Out    <= 1'b0;
            Alu_OP_Out     <= 2'b00;
            Valid_Out      <= 1'b0;
        end else if (!Stall_In) begin
            // Control values are taken as presented. The upstream mux is
            // responsible for zeroing them on hazards or IF/ID bubbles.
            Reg_Write_Out  <= Reg_Write_In;
            Mem_To_Reg_Out <= Mem_To_Reg_In;
            Mem_Read_Out   <= Mem_Read_In;
            Mem_Write_Out  <= Mem_Write_In;
            Reg_Dst_Out    <= Reg_Dst_In;
            Alu_Src_Out    <= Alu_Src_In;
            Alu_OP_Out     <= Alu_OP_In;
            Valid_Out      <= Valid_In;
        end
    end

    // Datapath fields: these also load on a flush, so the contents of a
    // bubble are deterministic rather than stale.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Read_Data_1_Out  <= '0;
            Read_Data_2_Out  <= '0;
            Sign_Ext_Imm_Out <= '0;
            PC_Plus4_Out     <= '0;
            Rs_Out           <= '0;
            Rt_Out           <= '0;
            Rd_Out           <= '0;
        end else if (Flush_In || !Stall_In) begin
            Read_Data_1_Out  <= Read_Data_1_In;
            Read_Data_2_Out  <= Read_Data_2_In;
            Sign_Ext_Imm_Out <= Sign_Ext_Imm_In;
            PC_Plus4_Out     <= PC_Plus4_In;
            Rs_Out           <= Rs_In;
            Rt_Out           <= Rt_In;
            Rd_Out           <= Rd_In;
        end
    end

    // Bubble counter: saturates at all-ones; a clear wins over an increment
    // in the same cycle.
    always_ff @(posedge Clk) begin
        if (Rst || Clear_Count_In) begin
            Bubble_Count_Out <= '0;
        end else if (bubble && !count_full) begin
            Bubble_Count_Out <= Bubble_Count_Out + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register (COUNT_WIDTH=4 so saturation is reachable).
// The driver applies one cycle of stimulus, updates a stage-level reference
// model and queues the expected EX-stage view. The monitor pops one entry
// after each rising edge and compares it with the DUT outputs.
module tb_id_ex_register;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef struct packed {
        logic          reg_write;
        logic          mem_to_reg;
        logic          mem_read;
        logic          mem_write;
        logic          reg_dst;
        logic          alu_src;
        logic [1:0]    alu_op;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } pay_t;

    typedef struct packed {
        pay_t          p;
        logic          valid;
        logic [CW-1:0] cnt;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b0, stall = 1'b0, flush = 1'b0, clr = 1'b0, valid_in = 1'b0;
    pay_t in_p = '0;
    ex_t  act;

    logic                reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, reg_dst_o, alu_src_o;
    logic [1:0]          alu_op_o;
    logic [DW-1:0]       rd1_o, rd2_o, imm_o, pc4_o;
    logic [AW-1:0]       rs_o, rt_o, rd_o;
    logic                valid_o;
    logic [CW-1:0]       cnt_o;

    always #5 clk = ~clk;

    id_ex_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .Clk(clk), .Rst(rst), .Stall_In(stall), .Flush_In(flush),
        .Clear_Count_In(clr), .Valid_In(valid_in),
        .Reg_Write_In(in_p.reg_write), .Mem_To_Reg_In(in_p.mem_to_reg),
        .Mem_Read_In(in_p.mem_read), .Mem_Write_In(in_p.mem_write),
        .Reg_Dst_In(in_p.reg_dst), .Alu_Src_In(in_p.alu_src), .Alu_OP_In(in_p.alu_op),
        .Read_Data_1_In(in_p.rd1), .Read_Data_2_In(in_p.rd2),
        .Sign_Ext_Imm_In(in_p.imm), .PC_Plus4_In(in_p.pc4),
        .Rs_In(in_p.rs), .Rt_In(in_p.rt), .Rd_In(in_p.rd),
        .Reg_Write_Out(reg_write_o), .Mem_To_Reg_Out(mem_to_reg_o),
        .Mem_Read_Out(mem_read_o), .Mem_Write_Out(mem_write_o),
        .Reg_Dst_Out(reg_dst_o), .Alu_Src_Out(alu_src_o), .Alu_OP_Out(alu_op_o),
        .Read_Data_1_Out(rd1_o), .Read_Data_2_Out(rd2_o),
        .Sign_Ext_Imm_Out(imm_o), .PC_Plus4_Out(pc4_o),
        .Rs_Out(rs_o), .Rt_Out(rt_o), .Rd_Out(rd_o),
        .Valid_Out(valid_o), .Bubble_Count_Out(cnt_o)
    );

    assign act = '{p: '{reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, reg_dst_o,
                        alu_src_o, alu_op_o, rd1_o, rd2_o, imm_o, pc4_o, rs_o, rt_o, rd_o},
                   valid: valid_o, cnt: cnt_o};

    int  total = 0;
    int  bad   = 0;
    ex_t exp_q[$];
    ex_t model = '0;
    int  bubbles = 0;
    string tag = "init";

    task automatic check(input string name, input ex_t got, input ex_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: the stage presents a new value after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check(tag, act, exp_q.pop_front());
        end
    end

    function automatic pay_t rand_pay();
        pay_t p;
        p.reg_write  = 1'($urandom);
        p.mem_to_reg = 1'($urandom);
        p.mem_read   = 1'($urandom);
        p.mem_write  = 1'($urandom);
        p.reg_dst    = 1'($urandom);
        p.alu_src    = 1'($urandom);
        p.alu_op     = 2'($urandom);
        p.rd1        = $urandom;
        p.rd2        = $urandom;
        p.imm        = $urandom;
        p.pc4        = $urandom;
        p.rs         = AW'($urandom);
        p.rt         = AW'($urandom);
        p.rd         = AW'($urandom);
        return p;
    endfunction

    // Reference model of the EX-stage view, stated as the stage's rules:
    // reset empties it; a flush inserts a bubble that carries the new
    // datapath; a stall freezes it; otherwise the ID instruction moves in.
    task automatic cycle(input string name, input pay_t p, input logic v,
                         input logic r, input logic s, input logic f, input logic c);
        bit entered_bubble;
        @(negedge clk);
        in_p = p; valid_in = v; rst = r; stall = s; flush = f; clr = c; tag = name;
        if (r) begin
            model   = '0;
            bubbles = 0;
        end else begin
            entered_bubble = f || (!s && !v);
            if (f) begin
                model.p = p;
                model.p.reg_write  = 1'b0;
                model.p.mem_to_reg = 1'b0;
                model.p.mem_read   = 1'b0;
                model.p.mem_write  = 1'b0;
                model.p.reg_dst    = 1'b0;
                model.p.alu_src    = 1'b0;
                model.p.alu_op     = 2'b00;
                model.valid = 1'b0;
            end else if (!s) begin
                model.p     = p;
                model.valid = v;
            end
            if (c) bubbles = 0;
            else if (entered_bubble) bubbles = (bubbles + 1 > 15) ? 15 : bubbles + 1;
        end
        model.cnt = CW'(bubbles);
        exp_q.push_back(model);
    endtask

    initial begin
        pay_t p;
        pay_t first;
        int   guard;

        repeat (2) @(negedge clk);

        // Reset with every input driven nonzero.
        p = '1;
        repeat (2) cycle("reset", p, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Single directed load.
        p = '0;
        p.reg_write = 1'b1; p.alu_op = 2'b10; p.rd1 = 32'h0000_0005; p.rt = 5'd9;
        cycle("load", p, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load, then stall for 3 cycles while inputs change.
        first = rand_pay();
        cycle("load2", first, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("stall", rand_pay(), 1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);

        // Flush and stall together: bubble with loaded datapath.
        p = rand_pay(); p.mem_read = 1'b1; p.rd2 = 32'hDEAD_BEEF;
        cycle("flush_stall", p, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Run IF/ID bubbles until the counter saturates, then clear it.
        for (int i = 0; i < 20; i++) cycle("saturate", rand_pay(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("clear_vs_inc", rand_pay(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-stream reset while stalled and flushed, then resume.
        cycle("pre_rst", rand_pay(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("mid_rst", rand_pay(), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("resume", rand_pay(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("random", rand_pay(),
                  ($urandom_range(99) < 75),
                  ($urandom_range(99) < 2),
                  ($urandom_range(99) < 20),
                  ($urandom_range(99) < 10),
                  ($urandom_range(99) < 5));
        end

        // Let the monitor drain the scoreboard, bounded.
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: left=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- ID/EX pipeline register of the 32-bit MIPS 5-stage pipeline.
- Sits directly downstream of the decode-stage control mux.
- Captures the 8 control bits (already zeroed by the mux on a load-use hazard), operand data, immediate, register numbers and PC+4 each cycle, and presents them to the EX stage.
- Supports stall (hold), flush (bubble insertion) and a saturating bubble counter for performance checks.

Parameters:
- DATA_WIDTH, 32, width of operands, immediate and PC+4
- REG_ADDR_WIDTH, 5, width of Rs/Rt/Rd register numbers
- COUNT_WIDTH, 16, width of bubble counter

Ports:
- Clk  input  1  pipeline clock, all state updates on rising edge
- Rst  input  1  synchronous active-high reset
- Stall_In  input  1  hold all stage contents this cycle
- Flush_In  input  1  replace captured instruction with a bubble
- Clear_Count_In  input  1  synchronous clear of bubble counter
- Valid_In  input  1  ID-stage instruction is real (not an IF/ID bubble)
- Reg_Write_In, Mem_To_Reg_In, Mem_Read_In, Mem_Write_In, Reg_Dst_In, Alu_Src_In  input  1 each  control bits from control mux
- Alu_OP_In  input  2  ALU op class from control mux
- Read_Data_1_In, Read_Data_2_In  input  DATA_WIDTH  register file outputs
- Sign_Ext_Imm_In  input  DATA_WIDTH  sign-extended immediate
- PC_Plus4_In  input  DATA_WIDTH  PC+4 of ID instruction
- Rs_In, Rt_In, Rd_In  input  REG_ADDR_WIDTH  instruction register fields
- Reg_Write_Out, Mem_To_Reg_Out, Mem_Read_Out, Mem_Write_Out, Reg_Dst_Out, Alu_Src_Out  output  1 each  registered control bits
- Alu_OP_Out  output  2  registered ALU op
- Read_Data_1_Out, Read_Data_2_Out, Sign_Ext_Imm_Out, PC_Plus4_Out  output  DATA_WIDTH  registered data
- Rs_Out, Rt_Out, Rd_Out  output  REG_ADDR_WIDTH  registered register numbers (used by forwarding unit)
- Valid_Out  output  1  EX-stage holds a real instruction
- Bubble_Count_Out  output  COUNT_WIDTH  number of bubbles entered into EX

Behaviour:
- One clock, synchronous active-high reset. Latency 1 cycle from ID inputs to outputs.
- Priority per rising edge: Rst > Flush_In > Stall_In > normal load.
- Rst: every output cleared to 0, including Valid_Out and Bubble_Count_Out. Reset asserted mid-operation discards the in-flight instruction; no partial state survives.
- Flush_In=1 (Stall_In ignored):
  - all 8 control bits and Valid_Out <= 0
  - data, immediate, PC+4 and Rs/Rt/Rd still load from inputs (don't-care in a bubble; loaded to keep the datapath deterministic)
  - counts as bubble
- Stall_In=1, Flush_In=0: all outputs hold; counter does not change.
- Normal load: every output <= corresponding input; Valid_Out <= Valid_In.
  - If Valid_In=0, control outputs still load as presented (the upstream mux already zeroes them) and the cycle counts as bubble.
  - A hazard-zeroed instruction with Valid_In=1 is the upstream's responsibility; the register does not inspect control values.
- Bubble counter:
  - on a bubble cycle, Bubble_Count_Out += 1, saturating at all-ones (no wrap)
  - Clear_Count_In=1 sets it to 0 on that edge, overriding any same-cycle increment
  - Rst also clears it
- No combinational path input→output; all outputs come straight from flops.

Test Plan:
- Rst=1 for 2 cycles with all inputs driven nonzero -> all outputs 0, Bubble_Count_Out=0.
- Load Reg_Write=1, Alu_OP=2'b10, Read_Data_1=32'h0000_0005, Rt=5'd9, Valid_In=1, no stall/flush -> next edge outputs match, Valid_Out=1, count unchanged.
- Load instruction, then Stall_In=1 for 3 cycles with changing inputs -> outputs frozen at the first instruction for all 3 cycles, count unchanged.
- Flush_In=1 and Stall_In=1 together with Mem_Read_In=1, Read_Data_2_In=32'hDEAD_BEEF -> Mem_Read_Out=0, Valid_Out=0, Read_Data_2_Out=32'hDEAD_BEEF, count +1.
- With COUNT_WIDTH=4, hold Valid_In=0 for 20 cycles -> count stops at 4'hF; then Clear_Count_In=1 together with Valid_In=0 -> count 0.
- Mid-stream Rst=1 while Stall_In=1 and Flush_In=1 -> all outputs 0 on that edge; release Rst -> normal loading resumes next edge.
